// File: rtl/efi_out_bank.sv
// N-channel angle-window output bank. The output logic reads an active register bank;
// new settings are written to a shadow bank and copied over on a tooth trigger or while unsynced.
module efi_out_bank #(
  parameter int NCH = 4,
  parameter int W   = 16,
  parameter int AW  = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  input  logic          commit_req,
  output logic          cfg_pending,
  input  logic [W-1:0]  eng_phase,
  input  logic          trigger,
  input  logic          synced,
  output logic [NCH-1:0] out,
  output logic          phase_err
);

  localparam int NREG = 2 * NCH + 2;
  localparam int CW   = NCH + 2;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_PEND = 1'b1;
  localparam logic [W-1:0] QPR_RST = W'(7680);

  // Control word: [NCH-1:0] enables, [NCH+1:NCH] mode. Other registers are indexed by address.
  logic [CW-1:0]  sh_ctrl_q, sh_ctrl_d, act_ctrl_q;
  logic [W-1:0]   sh_q  [1:NREG-1];
  logic [W-1:0]   sh_d  [1:NREG-1];
  logic [W-1:0]   act_q [1:NREG-1];
  logic           state_q, state_d;
  logic           copy;
  logic [W-1:0]   rd_d;
  logic [NCH-1:0] gated, out_d;
  logic [1:0]     mode;
  logic           in_rev;
  logic [W-1:0]   on_a, off_a;
  logic           raw;
  logic [NCH-1:0] out_q;
  logic [W-1:0]   rd_q;
  logic           err_q;

  always_comb begin
    sh_ctrl_d = sh_ctrl_q;
    sh_d      = sh_q;
    if (wr_en && wr_addr == '0) sh_ctrl_d = CW'(wr_data);
    for (int a = 1; a < NREG; a++) begin
      if (wr_en && wr_addr == AW'(a)) sh_d[a] = wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    copy    = 1'b0;
    case (state_q)
      ST_IDLE: if (commit_req) state_d = ST_PEND;
      default: begin
        if (trigger || !synced) begin
          copy    = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    rd_d = '0;
    if (rd_addr == '0) rd_d = W'(sh_ctrl_q);
    for (int a = 1; a < NREG; a++) begin
      if (rd_addr == AW'(a)) rd_d = sh_q[a];
    end
  end

  // Windows with on > off wrap through zero; on == off is an empty window.
  always_comb begin
    in_rev = eng_phase < act_q[1];
    gated  = '0;
    on_a   = '0;
    off_a  = '0;
    raw    = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      on_a  = act_q[2 + 2 * k];
      off_a = act_q[3 + 2 * k];
      raw   = 1'b0;
      if (on_a < off_a)      raw = (eng_phase >= on_a) && (eng_phase < off_a);
      else if (on_a > off_a) raw = (eng_phase >= on_a) || (eng_phase < off_a);
      gated[k] = raw && in_rev && synced && act_ctrl_q[k];
    end
  end

  assign mode = act_ctrl_q[CW-1:NCH];

  always_comb begin
    out_d = gated;
    case (mode)
      2'd1: begin
        out_d    = '0;
        out_d[0] = |gated;
      end
      2'd2: begin
        out_d = '0;
        for (int k = 0; k < NCH / 2; k++) out_d[k] = gated[k] | gated[k + NCH / 2];
      end
      default: out_d = gated;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_ctrl_q  <= '0;
      act_ctrl_q <= '0;
      for (int a = 1; a < NREG; a++) begin
        sh_q[a]  <= (a == 1) ? QPR_RST : '0;
        act_q[a] <= (a == 1) ? QPR_RST : '0;
      end
      state_q <= ST_IDLE;
      out_q   <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      sh_ctrl_q <= sh_ctrl_d;
      for (int a = 1; a < NREG; a++) sh_q[a] <= sh_d[a];
      // The copy takes the next shadow value so a same-cycle write is included.
      if (copy) begin
        act_ctrl_q <= sh_ctrl_d;
        for (int a = 1; a < NREG; a++) act_q[a] <= sh_d[a];
      end
      state_q <= state_d;
      out_q   <= out_d;
      rd_q    <= rd_d;
      err_q   <= err_q | (synced && !in_rev);
    end
  end

  assign out         = out_q;
  assign rd_data     = rd_q;
  assign cfg_pending = (state_q == ST_PEND);
  assign phase_err   = err_q;

endmodule

// File: doc/efi_out_bank.md
# efi_out_bank

Parametrised N-channel angle-window output bank for the EFI core. It replaces hard-wired per-cylinder output logic with one configurable block. Each channel asserts its output while the synchronizer's engine phase lies inside a programmable on/off angle window, with wrap-around at `quanta_per_rev`. Configuration is written into a shadow bank and committed atomically on a tooth trigger, so that a channel never sees a half-updated window. The block sits between the synchronizer (`eng_phase`, `trigger`, `synced`) and the coil/injector pins, with its write port fed from the SPI register latch.

## Interface
Parameters:
- `NCH`, default 4: channel count, even, 2..16.
- `W`, default 16: angle/data width.
- `AW`, default 6: config address width. Requires 2*NCH+2 <= 2^AW.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `wr_en`  in  1  shadow write strobe.
- `wr_addr`  in  AW  shadow register address.
- `wr_data`  in  W  shadow write data.
- `rd_addr`  in  AW  readback address.
- `rd_data`  out  W  shadow readback, registered.
- `commit_req`  in  1  one-cycle pulse requesting shadow→active copy.
- `cfg_pending`  out  1  commit requested but not yet applied.
- `eng_phase`  in  W  engine phase in quanta, from the synchronizer.
- `trigger`  in  1  one-cycle tooth-edge pulse.
- `synced`  in  1  synchronizer locked.
- `out`  out  NCH  channel outputs, registered.
- `phase_err`  out  1  sticky flag: `eng_phase` >= active `quanta_per_rev` seen while synced.

## Operation
- Register map (shadow and active banks are identical):
  - addr 0: control. [NCH-1:0] is the per-channel enable; [NCH+1:NCH] is the mode.
  - addr 1: `quanta_per_rev`.
  - addr 2+2k: on-angle for channel k.
  - addr 3+2k: off-angle for channel k.
- Writes to addresses >= 2*NCH+2 are ignored. Reads from those addresses return 0.
- Reset values, both banks: control=0, `quanta_per_rev`=7680, all angles=0.
- Reset values, outputs: `out`=0, `rd_data`=0, `cfg_pending`=0, `phase_err`=0.
- Raw window for channel k, using active bank values:
  - on < off: raw = on <= phase < off.
  - on > off (wraps through 0): raw = phase >= on OR phase < off.
  - on == off: raw = 0.
- If phase >= `quanta_per_rev`: all raw outputs are 0. If `synced`=1 in that cycle, `phase_err` is set. `phase_err` clears only on `rst`.
- Gating: raw[k] is ANDed with `synced` and en[k].
- Mode 0 (independent): out[k] = gated[k].
- Mode 1 (distributor): out[0] = OR of all gated[k]; out[k>0] = 0.
- Mode 2 (wasted-spark pairs): for k < NCH/2, out[k] = gated[k] | gated[k+NCH/2]; upper half = 0.
- Mode 3: behaves as mode 0.
- Commit state machine, two states:
  - IDLE: `commit_req` moves to PENDING.
  - PENDING: on a cycle with `trigger`=1, or with `synced`=0, copy the whole shadow bank to the active bank and return to IDLE.
  - `cfg_pending` = (state == PENDING).
- `commit_req` in PENDING has no effect, and is not queued.
- Simultaneous events:
  - `wr_en` in the same cycle as the applying copy: the new write value is included in the copy.
  - `wr_en` and `commit_req` in the same cycle: the write lands in shadow, and is applied by that commit.
  - `rst` mid-PENDING: returns to IDLE and both banks take reset values.
- Loss of `synced` mid-pulse: the output drops at the next registered update. It does not wait for the off-angle.

## Timing
- `out` is registered. `eng_phase`, `synced` and the active bank at edge n determine `out` after edge n (1-cycle latency).
- Commit:
  - `commit_req` high at edge n → `cfg_pending`=1 after edge n.
  - Copy at the first edge m > n with `trigger`=1 or `synced`=0 → `cfg_pending`=0 after edge m.
  - New windows are visible on `out` after edge m+1.
- Commit while `synced`=0 at the edge after `commit_req` applies at that edge, one cycle after the request.
- `rd_data` = shadow[`rd_addr`] one cycle after `rd_addr` is sampled. A same-cycle write is not yet visible; it reads back on the next cycle.
- Angle comparisons are unsigned, W bits wide. No arithmetic carries beyond W.

## Test plan
- Mode 0, NCH=4, ch0 on=100 off=200, en=0001, commit with `synced`=0, then `synced`=1 and sweep phase 0..7679: `out[0]` high exactly for phase 100..199, seen one cycle late; other outputs 0.
- Wrap window on=7600 off=50: `out[0]` high for 7600..7679 and 0..49; low at 50 and 7599. With on=off=300: never high.
- Atomic commit: while synced, write ch1 on=500 off=900 and pulse `commit_req`. `cfg_pending`=1 and `out` keeps the old window until the next `trigger`; after the trigger, `cfg_pending`=0 and the new window is active from the following cycle. A second `commit_req` while pending changes nothing.
- Modes:
  - mode 1 with ch0..ch3 windows at 0/2560/5120/…: all pulses appear on `out[0]`, and `out[3:1]`=0.
  - mode 2: ch0 and ch2 windows both drive `out[0]`; `out[3:2]`=0.
- Fault and sync: phase=7680 with `synced`=1 → `out`=0 and `phase_err`=1, held until `rst`. Dropping `synced` mid-window → `out` low one cycle later.
- Reset during PENDING: `rst` → `cfg_pending`=0, `out`=0, `rd_data` at addr 1 = 7680; writes to addr 63 are ignored and read back 0.
